// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder.
// A package cannot take parameters, so the sizing helpers receive WIDTH and CHUNK as arguments.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int unsigned nchunk_f(input int unsigned width, input int unsigned chunk);
        if (chunk == 0) return 1;
        return width / chunk;
    endfunction

    // Index width: $clog2(NCHUNK), never below 1 so a single-chunk build still has an index bit.
    function automatic int unsigned idx_w_f(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = nchunk_f(width, chunk);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

    function automatic bit params_ok_f(input int unsigned width, input int unsigned chunk);
        if (chunk == 0 || chunk > width) return 1'b0;
        return (width % chunk) == 0;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit for overflow.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] full;

    assign full     = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    assign s        = full[CHUNK-1:0];
    assign co       = full[CHUNK];
    // Carry into the top bit falls out of its sum bit and its two operand bits.
    assign c_msb_in = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Add/subtract two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int unsigned IW     = idx_w_f(WIDTH, CHUNK);

    if (!params_ok_f(WIDTH, CHUNK)) begin : g_param_check
        $error("serial_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    int unsigned      base;
    logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
    logic             chunk_co, chunk_msb_ci;

    assign base    = CHUNK * 32'(idx_q);
    assign chunk_x = a_q[base +: CHUNK];
    assign chunk_y = b_q[base +: CHUNK];

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x        (chunk_x),
        .y        (chunk_y),
        .ci       (carry_q),
        .s        (chunk_s),
        .co       (chunk_co),
        .c_msb_in (chunk_msb_ci)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                // Subtraction is folded in at capture: invert B and the borrow once.
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = chunk_s;
                carry_d              = chunk_co;
                idx_d                = idx_q + 1'b1;
                if (idx_q == IW'(NCHUNK - 1)) begin
                    cout_d  = chunk_co;
                    ovf_d   = chunk_msb_ci ^ chunk_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: three builds (CHUNK=4, 16, 1) against an arithmetic reference model.
module tb_serial_chunk_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0, sub = 1'b0;

    logic iv4 = 1'b0, or4 = 1'b1, ir4, ov4, co4, of4;
    logic iv16 = 1'b0, or16 = 1'b1, ir16, ov16, co16, of16;
    logic iv1 = 1'b0, or1 = 1'b1, ir1, ov1, co1, of1;
    logic [15:0] sum4, sum16, sum1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(co4), .ovf(of4));

    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(co16), .ovf(of16));

    serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(co1), .ovf(of1));

    // Reference: plain integer arithmetic on the operands as the user sees them.
    function automatic void model(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                                  input logic ts, output logic [15:0] es, output logic ec,
                                  output logic eo);
        int ua, ub, uc, sa, sb, r;
        ua = int'(ta);
        ub = int'(tb_);
        uc = tc ? 1 : 0;
        sa = ta[15] ? ua - 65536 : ua;
        sb = tb_[15] ? ub - 65536 : ub;
        if (!ts) begin
            es = 16'((ua + ub + uc) % 65536);
            ec = (ua + ub + uc) >= 65536;
            r  = sa + sb + uc;
        end else begin
            es = 16'((ua - ub - uc + 131072) % 65536);
            ec = ua >= ub + uc;
            r  = sa - sb - uc;
        end
        eo = (r > 32767) || (r < -32768);
    endfunction

    function automatic logic sel_ov(input int w);
        return (w == 0) ? ov4 : (w == 1) ? ov16 : ov1;
    endfunction

    function automatic int exp_lat(input int w);
        return (w == 0) ? 5 : (w == 1) ? 2 : 17;
    endfunction

    // Offer one op to the chosen build, wait (bounded) for its result, then release it.
    task automatic drive_op(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tc, input logic ts, output logic [15:0] rs,
                            output logic rc, output logic ro, output int lat, output int acc);
        a = ta; b = tb_; cin = tc; sub = ts;
        case (w)
            0: iv4 = 1'b1;
            1: iv16 = 1'b1;
            default: iv1 = 1'b1;
        endcase
        @(posedge clk); #1;
        acc = cyc;
        iv4 = 1'b0; iv16 = 1'b0; iv1 = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        while (!sel_ov(w) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = (w == 0) ? sum4 : (w == 1) ? sum16 : sum1;
        rc = (w == 0) ? co4 : (w == 1) ? co16 : co1;
        ro = (w == 0) ? of4 : (w == 1) ? of16 : of1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ov4, ov16, ov1} !== 3'b000) begin
            miscompares++; $display("FAIL reset_out_valid got %b want 000", {ov4, ov16, ov1});
        end
        vectors++;
        if ({sum4, co4, of4} !== 18'h0) begin
            miscompares++; $display("FAIL reset_result got %h/%b/%b want 0/0/0", sum4, co4, of4);
        end
        vectors++;
        if ({ir4, ir16, ir1} !== 3'b000) begin
            miscompares++; $display("FAIL reset_in_ready_in_rst got %b want 000", {ir4, ir16, ir1});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({ir4, ir16, ir1} !== 3'b111) begin
            miscompares++; $display("FAIL reset_in_ready_after got %b want 111", {ir4, ir16, ir1});
        end
    endtask

    task automatic check_op(input string nm, input int w, input logic [15:0] ta,
                            input logic [15:0] tb_, input logic tc, input logic ts);
        logic [15:0] rs, es;
        logic rc, ro, ec, eo;
        int lat, acc;
        model(ta, tb_, tc, ts, es, ec, eo);
        drive_op(w, ta, tb_, tc, ts, rs, rc, ro, lat, acc);
        vectors++;
        if (lat !== exp_lat(w)) begin
            miscompares++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat(w));
        end
        vectors++;
        if ({rs, rc, ro} !== {es, ec, eo}) begin
            miscompares++;
            $display("FAIL %s a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     nm, ta, tb_, tc, ts, rs, rc, ro, es, ec, eo);
        end
    endtask

    task automatic test_directed();
        check_op("add_basic", 0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        check_op("add_ripple", 0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check_op("add_ovf", 0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check_op("sub_borrow", 0, 16'h0005, 16'h0007, 1'b0, 1'b1);
        check_op("sub_ovf", 0, 16'h8000, 16'h0001, 1'b0, 1'b1);
        check_op("sub_borrow_in", 0, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            check_op("rand4", 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic test_rechunk();
        check_op("c16_a5", 1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        check_op("c1_a5", 2, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_op("rand16", 1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            check_op("rand1", 2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rs;
        logic rc, ro;
        int lat, acc, prev;
        drive_op(0, 16'h0102, 16'h0304, 1'b0, 1'b0, rs, rc, ro, lat, prev);
        for (int i = 0; i < 3; i++) begin
            drive_op(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, rs, rc, ro, lat, acc);
            vectors++;
            if (acc - prev !== 6) begin
                miscompares++; $display("FAIL throughput gap got %0d want 6", acc - prev);
            end
            prev = acc;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] es, s0;
        logic ec, eo, c0, o0;
        int lat;
        or4 = 1'b0;
        a = 16'h8001; b = 16'h8001; cin = 1'b1; sub = 1'b0; iv4 = 1'b1;
        model(16'h8001, 16'h8001, 1'b1, 1'b0, es, ec, eo);
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
        s0 = sum4; c0 = co4; o0 = of4;
        vectors++;
        if ({s0, c0, o0} !== {es, ec, eo}) begin
            miscompares++; $display("FAIL bp_result got %h/%b/%b want %h/%b/%b", s0, c0, o0, es, ec, eo);
        end
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({ov4, ir4, sum4, co4, of4} !== {1'b1, 1'b0, s0, c0, o0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got v=%b r=%b %h/%b/%b want v=1 r=0 %h/%b/%b",
                         i, ov4, ir4, sum4, co4, of4, s0, c0, o0);
            end
        end
        or4 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({ir4, ov4} !== 2'b10) begin
            miscompares++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", ir4, ov4);
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
        vectors++;
        if ({lat, sum4, co4, of4} !== {32'd5, 16'h3333, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL bp_next got lat=%0d %h/%b/%b want 5 3333/0/0", lat, sum4, co4, of4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int seen;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; iv4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({ov4, ir4, sum4, co4, of4} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_reset got v=%b r=%b %h/%b/%b want v=0 r=0 0000/0/0", ov4, ir4, sum4, co4, of4);
        end
        rst = 1'b0; iv4 = 1'b0;
        #1;
        vectors++;
        if (ir4 !== 1'b1) begin
            miscompares++; $display("FAIL abort_ready got %b want 1", ir4);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov4) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL abort_no_pulse got %0d valid cycles want 0", seen);
        end
        check_op("after_abort", 0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        test_rechunk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
